// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: per-register write scoreboard,
// dependency stall, and the branch hold/flush state machine beside Decode.
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | normal issue; a branch accept arms the branch hold
// WAIT_RESOLVE | Fetch held until Memory resolves the branch or timeout
// FLUSH        | one-cycle squash of wrong-path Fetch/Decode contents
module pipeline_hazard_ctrl #(
  parameter int NUM_REGS  = 16,
  parameter int IDX_WIDTH = 4,
  parameter int CNT_WIDTH = 2,
  parameter int TIMEOUT   = 8
) (
  input  logic                 I_CLOCK,
  input  logic                 I_LOCK,
  input  logic                 I_IssueValid,
  input  logic                 I_Src1Used,
  input  logic [IDX_WIDTH-1:0] I_Src1Idx,
  input  logic                 I_Src2Used,
  input  logic [IDX_WIDTH-1:0] I_Src2Idx,
  input  logic                 I_DestWrite,
  input  logic [IDX_WIDTH-1:0] I_DestIdx,
  input  logic                 I_IsBranch,
  input  logic                 I_WriteBackEnable,
  input  logic [IDX_WIDTH-1:0] I_WriteBackRegIdx,
  input  logic                 I_BranchResolved,
  input  logic                 I_BranchTaken,
  output logic                 O_IssueAccept,
  output logic                 O_DepStallSignal,
  output logic                 O_BranchStallSignal,
  output logic                 O_Flush,
  output logic [NUM_REGS-1:0]  O_BusyMask,
  output logic                 O_Error
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]     TMO_ONE  = TMO_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RESOLVE = 2'd1,
    FLUSH        = 2'd2
  } state_t;

  state_t                 state;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [CNT_WIDTH-1:0]   count [NUM_REGS];
  logic [NUM_REGS-1:0]    busy;
  logic [NUM_REGS-1:0]    inc;
  logic [NUM_REGS-1:0]    dec;
  logic                   dep;
  logic                   accept;
  logic                   branch_stall;
  logic                   flush;
  logic                   error;
  logic                   wb_orphan;
  logic                   resolve_stray;
  logic                   timeout_hit;

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = (count[r] != '0);
    end
  end

  // Hazards read the registered counters only: no writeback bypass.
  always_comb begin
    dep = I_IssueValid &
          ((I_Src1Used  & busy[I_Src1Idx]) |
           (I_Src2Used  & busy[I_Src2Idx]) |
           (I_DestWrite & (count[I_DestIdx] == CNT_MAX)));
    accept = I_IssueValid & ~dep & (state == IDLE);
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r] = accept & I_DestWrite & (I_DestIdx == IDX_WIDTH'(r));
      dec[r] = I_WriteBackEnable & (I_WriteBackRegIdx == IDX_WIDTH'(r)) &
               (count[r] != '0);
    end
  end

  always_comb begin
    wb_orphan     = I_WriteBackEnable & (count[I_WriteBackRegIdx] == '0);
    resolve_stray = I_BranchResolved & (state != WAIT_RESOLVE);
    timeout_hit   = (state == WAIT_RESOLVE) & ~I_BranchResolved &
                    (tmo_cnt == TMO_LAST);
  end

  // Simultaneous retire and re-issue to the same register cancel out.
  always_ff @(posedge I_CLOCK) begin
    if (!I_LOCK) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        count[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc[r] && !dec[r]) begin
          count[r] <= count[r] + CNT_ONE;
        end else if (dec[r] && !inc[r]) begin
          count[r] <= count[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (!I_LOCK) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      branch_stall <= 1'b0;
      flush        <= 1'b0;
      error        <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && I_IsBranch) begin
            state        <= WAIT_RESOLVE;
            tmo_cnt      <= '0;
            branch_stall <= 1'b1;
          end
        end
        WAIT_RESOLVE: begin
          if (I_BranchResolved && I_BranchTaken) begin
            state        <= FLUSH;
            flush        <= 1'b1;
            branch_stall <= 1'b1;
          end else if (I_BranchResolved) begin
            state        <= IDLE;
            branch_stall <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            state        <= IDLE;
            branch_stall <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        FLUSH: begin
          state        <= IDLE;
          branch_stall <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          branch_stall <= 1'b0;
        end
      endcase
      if (wb_orphan || resolve_stray || timeout_hit) begin
        error <= 1'b1;
      end
    end
  end

  assign O_IssueAccept       = accept;
  assign O_DepStallSignal    = dep;
  assign O_BranchStallSignal = branch_stall;
  assign O_Flush             = flush;
  assign O_BusyMask          = busy;
  assign O_Error             = error;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stimulus pushes per-cycle expected
// outputs into a queue, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  logic        I_CLOCK = 1'b0;
  logic        I_LOCK;
  logic        I_IssueValid, I_Src1Used, I_Src2Used, I_DestWrite, I_IsBranch;
  logic [3:0]  I_Src1Idx, I_Src2Idx, I_DestIdx, I_WriteBackRegIdx;
  logic        I_WriteBackEnable, I_BranchResolved, I_BranchTaken;
  logic        O_IssueAccept, O_DepStallSignal, O_BranchStallSignal, O_Flush, O_Error;
  logic [15:0] O_BusyMask;

  typedef struct packed {
    logic        acc;
    logic        dep;
    logic        bst;
    logic        fl;
    logic [15:0] busy;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  pipeline_hazard_ctrl #(.NUM_REGS(16), .IDX_WIDTH(4), .CNT_WIDTH(2), .TIMEOUT(8)) dut (
    .I_CLOCK(I_CLOCK), .I_LOCK(I_LOCK),
    .I_IssueValid(I_IssueValid),
    .I_Src1Used(I_Src1Used), .I_Src1Idx(I_Src1Idx),
    .I_Src2Used(I_Src2Used), .I_Src2Idx(I_Src2Idx),
    .I_DestWrite(I_DestWrite), .I_DestIdx(I_DestIdx),
    .I_IsBranch(I_IsBranch),
    .I_WriteBackEnable(I_WriteBackEnable), .I_WriteBackRegIdx(I_WriteBackRegIdx),
    .I_BranchResolved(I_BranchResolved), .I_BranchTaken(I_BranchTaken),
    .O_IssueAccept(O_IssueAccept), .O_DepStallSignal(O_DepStallSignal),
    .O_BranchStallSignal(O_BranchStallSignal), .O_Flush(O_Flush),
    .O_BusyMask(O_BusyMask), .O_Error(O_Error)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at check cycle %0d: got %h expected %h", nm, cyc, act, want);
    end
  endtask

  always @(negedge I_CLOCK) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      cmp("issue_accept", {15'b0, O_IssueAccept},       {15'b0, e.acc});
      cmp("dep_stall",    {15'b0, O_DepStallSignal},    {15'b0, e.dep});
      cmp("branch_stall", {15'b0, O_BranchStallSignal}, {15'b0, e.bst});
      cmp("flush",        {15'b0, O_Flush},             {15'b0, e.fl});
      cmp("busy_mask",    O_BusyMask,                   e.busy);
      cmp("error",        {15'b0, O_Error},             {15'b0, e.err});
      cyc++;
    end
  end

  task automatic clr();
    I_LOCK = 1'b1;
    I_IssueValid = 0; I_Src1Used = 0; I_Src2Used = 0; I_DestWrite = 0; I_IsBranch = 0;
    I_Src1Idx = 0; I_Src2Idx = 0; I_DestIdx = 0; I_WriteBackRegIdx = 0;
    I_WriteBackEnable = 0; I_BranchResolved = 0; I_BranchTaken = 0;
  endtask

  task automatic issue(input logic s1u, input logic [3:0] s1, input logic s2u,
                       input logic [3:0] s2, input logic dw, input logic [3:0] d,
                       input logic br);
    I_IssueValid = 1; I_Src1Used = s1u; I_Src1Idx = s1; I_Src2Used = s2u;
    I_Src2Idx = s2; I_DestWrite = dw; I_DestIdx = d; I_IsBranch = br;
  endtask

  task automatic wb(input logic [3:0] r);
    I_WriteBackEnable = 1; I_WriteBackRegIdx = r;
  endtask

  task automatic resolve(input logic taken);
    I_BranchResolved = 1; I_BranchTaken = taken;
  endtask

  // Expected outputs for the cycle whose inputs are currently driven.
  task automatic step(input logic acc, input logic dep, input logic bst, input logic fl,
                      input logic [15:0] busy, input logic err);
    exp_t e;
    e = '{acc: acc, dep: dep, bst: bst, fl: fl, busy: busy, err: err};
    q.push_back(e);
    @(posedge I_CLOCK);
    #1;
    clr();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    clr();
    I_LOCK = 0;
    @(posedge I_CLOCK);
    #1;
    I_LOCK = 0;
    step(0, 0, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 0, 16'h0000, 0);

    // RAW on R3
    issue(0, 0, 0, 0, 1, 3, 0); step(1, 0, 0, 0, 16'h0000, 0);
    issue(1, 3, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 16'h0008, 0);
    issue(1, 3, 0, 0, 0, 0, 0); wb(3); step(0, 1, 0, 0, 16'h0008, 0);
    issue(1, 3, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 16'h0000, 0);

    // Saturation on R5
    issue(0, 0, 0, 0, 1, 5, 0); step(1, 0, 0, 0, 16'h0000, 0);
    issue(0, 0, 0, 0, 1, 5, 0); step(1, 0, 0, 0, 16'h0020, 0);
    issue(0, 0, 0, 0, 1, 5, 0); step(1, 0, 0, 0, 16'h0020, 0);
    issue(0, 0, 0, 0, 1, 5, 0); step(0, 1, 0, 0, 16'h0020, 0);
    issue(0, 0, 0, 0, 1, 5, 0); wb(5); step(0, 1, 0, 0, 16'h0020, 0);
    issue(0, 0, 0, 0, 1, 5, 0); wb(5); step(1, 0, 0, 0, 16'h0020, 0);
    issue(0, 0, 0, 0, 1, 5, 0); step(1, 0, 0, 0, 16'h0020, 0);
    issue(0, 0, 0, 0, 1, 5, 0); step(0, 1, 0, 0, 16'h0020, 0);
    issue(0, 0, 1, 5, 0, 0, 0); step(0, 1, 0, 0, 16'h0020, 0);
    issue(0, 5, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 16'h0020, 0);
    for (int i = 0; i < 3; i++) begin
      wb(5); step(0, 0, 0, 0, 16'h0020, 0);
    end
    step(0, 0, 0, 0, 16'h0000, 0);

    // Taken branch that also writes R7
    issue(0, 0, 0, 0, 1, 7, 1); step(1, 0, 0, 0, 16'h0000, 0);
    step(0, 0, 1, 0, 16'h0080, 0);
    issue(0, 0, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 16'h0080, 0);
    resolve(1); step(0, 0, 1, 0, 16'h0080, 0);
    issue(0, 0, 0, 0, 0, 0, 0); step(0, 0, 1, 1, 16'h0080, 0);
    issue(0, 0, 0, 0, 0, 0, 0); wb(7); step(1, 0, 0, 0, 16'h0080, 0);
    step(0, 0, 0, 0, 16'h0000, 0);

    // Not-taken branch
    issue(0, 0, 0, 0, 0, 0, 1); step(1, 0, 0, 0, 16'h0000, 0);
    step(0, 0, 1, 0, 16'h0000, 0);
    resolve(0); step(0, 0, 1, 0, 16'h0000, 0);
    issue(0, 0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 0, 16'h0000, 0);

    // Timeout with no resolve
    issue(0, 0, 0, 0, 0, 0, 1); step(1, 0, 0, 0, 16'h0000, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 16'h0000, 0);
    end
    step(0, 0, 0, 0, 16'h0000, 1);
    I_LOCK = 0; step(0, 0, 0, 0, 16'h0000, 1);
    step(0, 0, 0, 0, 16'h0000, 0);

    // Orphan writeback to R9, R2 in flight is untouched
    issue(0, 0, 0, 0, 1, 2, 0); step(1, 0, 0, 0, 16'h0000, 0);
    wb(9); step(0, 0, 0, 0, 16'h0004, 0);
    step(0, 0, 0, 0, 16'h0004, 1);
    I_LOCK = 0; step(0, 0, 0, 0, 16'h0004, 1);
    step(0, 0, 0, 0, 16'h0000, 0);

    // Stray resolve in IDLE
    resolve(1); step(0, 0, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 0, 16'h0000, 1);
    I_LOCK = 0; step(0, 0, 0, 0, 16'h0000, 1);
    step(0, 0, 0, 0, 16'h0000, 0);

    // Reset in the middle of WAIT_RESOLVE with R4 in flight
    issue(0, 0, 0, 0, 1, 4, 1); step(1, 0, 0, 0, 16'h0000, 0);
    step(0, 0, 1, 0, 16'h0010, 0);
    I_LOCK = 0; step(0, 0, 1, 0, 16'h0010, 0);
    issue(0, 0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 0, 16'h0000, 0);

    @(negedge I_CLOCK);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
